// File: rtl/fire_pkg.sv
// Shared fire-detection definitions: channel FSM encoding and default thresholds.
package fire_pkg;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t StLow     = 2'd0;
  localparam chan_state_t StRising  = 2'd1;
  localparam chan_state_t StHigh    = 2'd2;
  localparam chan_state_t StFalling = 2'd3;

  localparam int unsigned TempOnDef   = 60;
  localparam int unsigned TempOffDef  = 55;
  localparam int unsigned SmokeOnDef  = 100;
  localparam int unsigned SmokeOffDef = 80;
  localparam int unsigned DebounceDef = 4;
  localparam int unsigned TimeoutDef  = 1000;

endpackage

// File: rtl/fire_sense_chan.sv
// One sensor channel: hysteresis thresholds with consecutive-sample debounce.
module fire_sense_chan
  import fire_pkg::*;
#(
  parameter int unsigned ON       = TempOnDef,
  parameter int unsigned OFF      = TempOffDef,
  parameter int unsigned DEBOUNCE = DebounceDef
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] sample,
  output logic       level
);

  localparam logic [7:0] OnTh  = ON[7:0];
  localparam logic [7:0] OffTh = OFF[7:0];
  localparam logic [3:0] DebTh = DEBOUNCE[3:0];

  chan_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cnt_inc;
  logic        above_on, below_off;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    above_on  = (sample >= OnTh);
    below_off = (sample <= OffTh);
    if (en) begin
      unique case (state_q)
        StLow: begin
          cnt_d = '0;
          if (above_on) begin
            if (DebTh == 4'd1) state_d = StHigh;
            else begin
              state_d = StRising;
              cnt_d   = 4'd1;
            end
          end
        end
        StRising: begin
          if (!above_on) begin
            state_d = StLow;
            cnt_d   = '0;
          end else if (cnt_inc >= DebTh) begin
            state_d = StHigh;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHigh: begin
          cnt_d = '0;
          if (below_off) begin
            if (DebTh == 4'd1) state_d = StLow;
            else begin
              state_d = StFalling;
              cnt_d   = 4'd1;
            end
          end
        end
        StFalling: begin
          if (!below_off) begin
            state_d = StHigh;
            cnt_d   = '0;
          end else if (cnt_inc >= DebTh) begin
            state_d = StLow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StLow;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLow;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stays asserted while a release is still being debounced.
  assign level = (state_q == StHigh) || (state_q == StFalling);

endmodule

// File: rtl/fire_sense.sv
// Heat/smoke detector front end with sample-stream stall watchdog.
module fire_sense
  import fire_pkg::*;
#(
  parameter int unsigned TEMP_ON   = TempOnDef,
  parameter int unsigned TEMP_OFF  = TempOffDef,
  parameter int unsigned SMOKE_ON  = SmokeOnDef,
  parameter int unsigned SMOKE_OFF = SmokeOffDef,
  parameter int unsigned DEBOUNCE  = DebounceDef,
  parameter int unsigned TIMEOUT   = TimeoutDef
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] temp_in,
  input  logic [7:0] smoke_in,
  output logic       heat_signal,
  output logic       smoke_signal,
  output logic       sensor_fault
);

  localparam logic [15:0] TmoTh = TIMEOUT[15:0];

  logic [15:0] tmo_q, tmo_d;
  logic        smoke_level;

  // Channels only see samples; with no samples they hold, so a fault freezes them
  // and the sample that ends the fault is processed normally.
  fire_sense_chan #(
    .ON       (TEMP_ON),
    .OFF      (TEMP_OFF),
    .DEBOUNCE (DEBOUNCE)
  ) u_heat (
    .clk    (clk),
    .reset  (reset),
    .en     (sample_valid),
    .sample (temp_in),
    .level  (heat_signal)
  );

  fire_sense_chan #(
    .ON       (SMOKE_ON),
    .OFF      (SMOKE_OFF),
    .DEBOUNCE (DEBOUNCE)
  ) u_smoke (
    .clk    (clk),
    .reset  (reset),
    .en     (sample_valid),
    .sample (smoke_in),
    .level  (smoke_level)
  );

  always_comb begin
    tmo_d = tmo_q;
    if (sample_valid)       tmo_d = '0;
    else if (tmo_q < TmoTh) tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign sensor_fault = (tmo_q == TmoTh);
  assign smoke_signal = smoke_level | sensor_fault;

endmodule

// File: tb/tb_fire_sense.sv
// Randomized and directed checks of fire_sense against a behavioural model.
module tb_fire_sense;

  localparam int TOn = 60, TOff = 55, SOn = 100, SOff = 80, Deb = 4, Tmo = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] temp_in = '0, smoke_in = '0;
  logic       heat_signal, smoke_signal, sensor_fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: detected level plus length of the current run of qualifying samples.
  bit m_heat, m_smoke;
  int run_heat, run_smoke, idle;

  always #5 clk = ~clk;

  fire_sense dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .temp_in      (temp_in),
    .smoke_in     (smoke_in),
    .heat_signal  (heat_signal),
    .smoke_signal (smoke_signal),
    .sensor_fault (sensor_fault)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  function automatic void chan_update(input int x, input int on_th, input int off_th,
                                      inout bit lvl, inout int run);
    bit qual = lvl ? (x <= off_th) : (x >= on_th);
    run = qual ? run + 1 : 0;
    if (run >= Deb) begin
      lvl = ~lvl;
      run = 0;
    end
  endfunction

  // One clock: drive, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit v, input int t, input int s, input bit r);
    bit exp_fault;
    reset = r;
    sample_valid = v;
    temp_in = 8'(t);
    smoke_in = 8'(s);
    @(posedge clk);
    if (r) begin
      m_heat = 0; m_smoke = 0; run_heat = 0; run_smoke = 0; idle = 0;
    end else if (v) begin
      idle = 0;
      chan_update(t, TOn, TOff, m_heat, run_heat);
      chan_update(s, SOn, SOff, m_smoke, run_smoke);
    end else if (idle < Tmo) begin
      idle++;
    end
    @(negedge clk);
    exp_fault = (idle == Tmo);
    check_bit("heat", heat_signal, m_heat);
    check_bit("smoke", smoke_signal, m_smoke | exp_fault);
    check_bit("fault", sensor_fault, exp_fault);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    step(1, 90, 120, 1);  // sample coincident with reset is ignored
    check_bit("rst_heat", heat_signal, 1'b0);
    check_bit("rst_smoke", smoke_signal, 1'b0);
    check_bit("rst_fault", sensor_fault, 1'b0);

    // Four samples at exactly TEMP_ON assert heat.
    for (int i = 0; i < 3; i++) step(1, 60, 0, 0);
    check_bit("heat_3rd", heat_signal, 1'b0);
    step(1, 60, 0, 0);
    check_bit("heat_4th", heat_signal, 1'b1);
    check_bit("smoke_quiet", smoke_signal, 1'b0);

    // Hysteresis band holds, four at TEMP_OFF release.
    for (int i = 0; i < 10; i++) step(1, 58, 0, 0);
    check_bit("band_hold", heat_signal, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 55, 0, 0);
    check_bit("fall_3rd", heat_signal, 1'b1);
    step(1, 55, 0, 0);
    check_bit("fall_4th", heat_signal, 1'b0);

    // Broken rising run.
    step(1, 70, 0, 0); step(1, 70, 0, 0); step(1, 50, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 70, 0, 0);
    check_bit("broken_run", heat_signal, 1'b0);
    step(1, 70, 0, 0);
    check_bit("run_after_break", heat_signal, 1'b1);

    // Reset aborts smoke debounce.
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 100, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 100, 0);
    check_bit("smoke_reset_abort", smoke_signal, 1'b0);

    // Timeout fault and fail-safe smoke, cleared by one sample.
    step(1, 0, 0, 0);
    idle_cycles(999);
    check_bit("fault_999", sensor_fault, 1'b0);
    step(0, 0, 0, 0);
    check_bit("fault_1000", sensor_fault, 1'b1);
    check_bit("smoke_forced", smoke_signal, 1'b1);
    step(1, 0, 0, 0);
    check_bit("fault_clear", sensor_fault, 1'b0);
    check_bit("smoke_unforced", smoke_signal, 1'b0);

    // Sample on the 1000th idle cycle wins.
    idle_cycles(999);
    step(1, 0, 0, 0);
    check_bit("fault_race", sensor_fault, 1'b0);

    // Randomized traffic near both thresholds, with long gaps and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) idle_cycles(int'($urandom_range(995, 1010)));
      step(bit'($urandom_range(0, 1)), int'($urandom_range(50, 65)),
           int'($urandom_range(75, 105)), $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fire_sense.md
FIRE_SENSE -- requirements
Module: fire_sense

Interface
REQ-001 SHALL have parameter TEMP_ON, default 60, heat assert threshold (raw units, >=).
REQ-002 SHALL have parameter TEMP_OFF, default 55, heat release threshold (<=); TEMP_OFF < TEMP_ON.
REQ-003 SHALL have parameter SMOKE_ON, default 100, smoke assert threshold (>=).
REQ-004 SHALL have parameter SMOKE_OFF, default 80, smoke release threshold (<=); SMOKE_OFF < SMOKE_ON.
REQ-005 SHALL have parameter DEBOUNCE, default 4, consecutive qualifying samples needed to change an output (range 1..15).
REQ-006 SHALL have parameter TIMEOUT, default 1000, idle cycles without sample_valid before fault (range 2..65535).
REQ-007 SHALL have ports: clk in 1 system clock; reset in 1, synchronous, active-high.
REQ-008 SHALL have ports: sample_valid in 1, one-cycle strobe qualifying temp_in/smoke_in; temp_in in 8, unsigned raw temperature; smoke_in in 8, unsigned raw smoke density.
REQ-009 SHALL have ports: heat_signal out 1 and smoke_signal out 1, debounced detections driving the fire controller; sensor_fault out 1, sample stream stalled.

Function
REQ-010 SHALL process each channel (heat, smoke) independently with a 4-state FSM: LOW, RISING, HIGH, FALLING.
REQ-011 SHALL evaluate a channel only in cycles with sample_valid=1; other cycles leave FSM and counter unchanged.
REQ-012 LOW: sample >= ON threshold -> RISING, count=1 (if DEBOUNCE=1 go directly to HIGH); else stay, count=0.
REQ-013 RISING: sample >= ON -> count+1, reaching DEBOUNCE -> HIGH; sample < ON -> LOW, count=0.
REQ-014 HIGH: sample <= OFF -> FALLING, count=1 (DEBOUNCE=1 -> LOW); samples in hysteresis band (OFF < x < ON) keep HIGH.
REQ-015 FALLING: sample <= OFF -> count+1, reaching DEBOUNCE -> LOW; sample > OFF -> HIGH, count=0.
REQ-016 Channel output SHALL be 1 in HIGH and FALLING, 0 in LOW and RISING; registered, asserting/deasserting the cycle after the DEBOUNCE-th qualifying sample is accepted.
REQ-017 Debounce counter SHALL be 4 bits, saturating, never wrapping.
REQ-018 Timeout counter SHALL clear on every sample_valid and increment otherwise, saturating at TIMEOUT.
REQ-019 sensor_fault SHALL assert the cycle the timeout counter reaches TIMEOUT and deassert the cycle after the next sample_valid.
REQ-020 While sensor_fault=1, smoke_signal SHALL be forced 1 (fail-safe alarm); heat_signal holds its FSM value; FSMs are frozen.
REQ-021 sample_valid arriving in the same cycle the counter would reach TIMEOUT SHALL win: no fault, counter cleared, sample processed.
REQ-022 The sample that clears a fault SHALL be processed normally by both FSMs.

Reset
REQ-023 reset=1 at a clock edge SHALL put both FSMs in LOW and clear debounce and timeout counters, regardless of in-progress debounce or fault.
REQ-024 Outputs after reset SHALL be heat_signal=0, smoke_signal=0, sensor_fault=0.
REQ-025 sample_valid coincident with reset SHALL be ignored.

Structure
REQ-026 The FSM state encoding (LOW, RISING, HIGH, FALLING) and default threshold constants SHALL reside in the shared fire package used by the fire controller.
REQ-027 Per-channel hysteresis/debounce logic SHALL be a sub-module fire_sense_chan (parameters ON, OFF, DEBOUNCE; ports clk, reset, en, sample[7:0], level), instantiated twice.
REQ-028 Timeout and fault-forcing logic SHALL reside in the top level.

Verification
REQ-029 Reset then four samples temp=60, smoke=0 -> heat_signal=1 one cycle after fourth sample; smoke_signal=0.
REQ-030 Samples temp=70,70,50,70,70,70,70 -> heat_signal stays 0 until after the seventh (third sample breaks RISING).
REQ-031 From heat HIGH, samples temp=58 x10 -> heat_signal stays 1; then temp=55 x4 -> heat_signal=0 after fourth.
REQ-032 smoke=100 x3 then reset pulse then smoke=100 x3 -> smoke_signal remains 0 throughout.
REQ-033 No sample_valid for 1000 cycles -> sensor_fault=1 and smoke_signal=1 at count 1000; one sample smoke=0 -> both return to 0 next cycle.
REQ-034 sample_valid on exactly the 1000th idle cycle -> sensor_fault never asserts.
